// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci run sequencer: FSM states, overflow limit and result entry.
package fib_pkg;

  // Largest index whose Fibonacci value fits in 32 bits.
  localparam int FIB_MAX_IDX32 = 47;
  localparam int FIB_N_W_DEF   = 8;
  localparam int FIB_F_W_DEF   = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WAIT2,
    PUSH
  } fib_state_e;

  typedef struct packed {
    logic [FIB_N_W_DEF-1:0] num;
    logic [FIB_F_W_DEF-1:0] fib;
    logic                   err;
  } fib_entry_t;

endpackage

// File: rtl/fib_sequencer_if.sv
// Core-side and result-side signal bundle of fib_sequencer; master is the sequencer.
interface fib_sequencer_if #(
  parameter int N_W = 8,
  parameter int F_W = 32
);
  logic [N_W-1:0] core_num;
  logic           core_start;
  logic [F_W-1:0] core_fib;
  logic           core_done;

  logic           res_valid;
  logic           res_ready;
  logic [N_W-1:0] res_num;
  logic [F_W-1:0] res_fib;
  logic           res_err;

  modport master (
    output core_num, core_start,
    input  core_fib, core_done,
    output res_valid, res_num, res_fib, res_err,
    input  res_ready
  );

  modport slave (
    input  core_num, core_start,
    output core_fib, core_done,
    input  res_valid, res_num, res_fib, res_err,
    output res_ready
  );
endinterface

// File: rtl/fib_result_fifo.sv
// Synchronous result FIFO; head is shown combinationally and forced to zero while empty.
module fib_result_fifo
  import fib_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fib_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fib_sequencer.sv
// Walks indices first..last through an external Fibonacci core and queues {n, fib, err}.
// Optional FIB_OVERFLOW_CHECK_EN: indices above FIB_MAX_IDX32 skip the core and report err.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int N_W   = 8,
  parameter int F_W   = 32,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N_W-1:0] cfg_first,
  input  logic [N_W-1:0] cfg_last,
  input  logic           go,
  output logic           busy,
  fib_sequencer_if.master bus
);

`ifdef FIB_OVERFLOW_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct packed {
    logic [N_W-1:0] num;
    logic [F_W-1:0] fib;
    logic           err;
  } entry_t;

  fib_state_e     state;
  logic [N_W-1:0] n;
  logic [N_W-1:0] n_inc;
  logic [N_W-1:0] last_q;
  logic [F_W-1:0] fib_q;
  logic           err_q;
  logic           start_q;

  entry_t         wr_entry;
  entry_t         rd_entry;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop_fire;
  logic           can_push;
  logic           push_fire;

  function automatic logic is_ovf(input logic [N_W-1:0] idx);
    return OVF_EN && (32'(idx) > 32'(FIB_MAX_IDX32));
  endfunction

  assign n_inc     = n + 1'b1;
  assign pop_fire  = !fifo_empty && bus.res_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign can_push  = !fifo_full || pop_fire;
  assign push_fire = (state == PUSH) && can_push;

  assign wr_entry.num = n;
  assign wr_entry.fib = fib_q;
  assign wr_entry.err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      start_q <= 1'b0;
      n       <= '0;
      last_q  <= '0;
      fib_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go && (cfg_first <= cfg_last)) begin
            n       <= cfg_first;
            last_q  <= cfg_last;
            start_q <= !is_ovf(cfg_first);
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          if (is_ovf(n)) begin
            fib_q <= '0;
            err_q <= 1'b1;
            state <= PUSH;
          end else begin
            state <= WAIT;
          end
        end
        // core_done may still be high from the previous index for this one cycle.
        WAIT: state <= WAIT2;
        WAIT2: begin
          if (bus.core_done) begin
            fib_q <= bus.core_fib;
            err_q <= 1'b0;
            state <= PUSH;
          end
        end
        PUSH: begin
          if (can_push) begin
            // Compare before incrementing so last = all-ones ends without wrapping.
            if (n == last_q) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              n       <= n_inc;
              start_q <= !is_ovf(n_inc);
              state   <= ISSUE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.core_num   = n;
  assign bus.core_start = start_q;

  fib_result_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_fire),
    .pop   (pop_fire),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.res_valid = !fifo_empty;
  assign bus.res_num   = rd_entry.num;
  assign bus.res_fib   = rd_entry.fib;
  assign bus.res_err   = rd_entry.err;

endmodule
